rca_8_bit: RTL and testbench

- Registered 8-bit ripple-carry adder: sum = in1 + in2 + cin, with carry-out.
- Built from a chain of 1-bit full adders; the combinational result is captured in output registers on the clock edge.
- Arithmetic leaf block inside the team's datapath; consumers read sum/cout one cycle after a valid input.

---
 rtl/rca_pkg.sv | 15 +
 rtl/rca_8_bit_if.sv | 46 ++++
 rtl/rca_full_adder.sv | 22 ++
 rtl/rca_8_bit.sv | 74 +++++++
 tb/tb_rca_8_bit.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/rca_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rca_pkg                                                    |
// | Brief   : Shared width default and result-word type for the adder.   |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package rca_pkg;

  localparam int RCA_DEFAULT_WIDTH = 8;

  // {cout, sum} as one word, so a plain addition yields both fields.
  typedef logic [RCA_DEFAULT_WIDTH:0] rca_result_t;

endpackage : rca_pkg
`default_nettype wire

// File: rtl/rca_8_bit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rca_8_bit_if                                               |
// | Brief   : Operand/result bundle; RCA_OVERFLOW_FLAG_EN adds ovf.      |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface rca_8_bit_if
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_DEFAULT_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;

`ifdef RCA_OVERFLOW_FLAG_EN
  logic             ovf;

  modport master (
    output in_valid, in1, in2, cin,
    input  sum, cout, out_valid, ovf
  );

  modport slave (
    input  in_valid, in1, in2, cin,
    output sum, cout, out_valid, ovf
  );
`else
  modport master (
    output in_valid, in1, in2, cin,
    input  sum, cout, out_valid
  );

  modport slave (
    input  in_valid, in1, in2, cin,
    output sum, cout, out_valid
  );
`endif

endinterface : rca_8_bit_if
`default_nettype wire

// File: rtl/rca_full_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rca_full_adder                                             |
// | Brief   : Purely combinational 1-bit full adder.                     |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);

endmodule : rca_full_adder
`default_nettype wire

// File: rtl/rca_8_bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rca_8_bit                                                  |
// | Brief   : Registered ripple-carry adder, 1-cycle latency. Optional   |
// |           signed overflow flag via RCA_OVERFLOW_FLAG_EN.             |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rca_8_bit
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  rca_8_bit_if.slave   bus
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;

  assign w_c[0] = bus.cin;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      rca_full_adder u_fa (
        .a  (bus.in1[i]),
        .b  (bus.in2[i]),
        .ci (w_c[i]),
        .s  (w_s[i]),
        .co (w_c[i+1])
      );
    end
  endgenerate

  // Result registers hold their value while in_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_sum  <= w_s;
        r_cout <= w_c[WIDTH];
      end
    end
  end

  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.out_valid = r_out_valid;

`ifdef RCA_OVERFLOW_FLAG_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (bus.in_valid) begin
      r_ovf <= w_c[WIDTH] ^ w_c[WIDTH-1];
    end
  end

  assign bus.ovf = r_ovf;
`endif

endmodule : rca_8_bit
`default_nettype wire

// File: tb/tb_rca_8_bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_rca_8_bit                                               |
// | Brief   : Self-checking bench for rca_8_bit with arithmetic model.   |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_rca_8_bit;
  import rca_pkg::*;

  localparam int W = RCA_DEFAULT_WIDTH;

  logic clk;
  logic rst;
  int   tests;
  int   failed;
  bit   run_cmp;

  rca_8_bit_if #(.WIDTH(W)) bus ();

  rca_8_bit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model expectations: arithmetic on the whole result word.
  rca_result_t exp_res;
  logic        exp_valid;
  logic        exp_ovf;

  function automatic rca_result_t model_add(logic [W-1:0] a, logic [W-1:0] b, logic c);
    return rca_result_t'(a) + rca_result_t'(b) + rca_result_t'(c);
  endfunction

  function automatic logic model_ovf(logic [W-1:0] a, logic [W-1:0] b, logic c);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    return (s > 127) || (s < -128);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_res   <= '0;
      exp_valid <= 1'b0;
      exp_ovf   <= 1'b0;
    end else begin
      exp_valid <= bus.in_valid;
      if (bus.in_valid) begin
        exp_res <= model_add(bus.in1, bus.in2, bus.cin);
        exp_ovf <= model_ovf(bus.in1, bus.in2, bus.cin);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("model_sum",   32'(bus.sum),       32'(exp_res[W-1:0]));
      chk("model_cout",  32'(bus.cout),      32'(exp_res[W]));
      chk("model_valid", 32'(bus.out_valid), 32'(exp_valid));
`ifdef RCA_OVERFLOW_FLAG_EN
      chk("model_ovf",   32'(bus.ovf),       32'(exp_ovf));
`endif
    end
  end

  task automatic step(logic v, logic [W-1:0] a, logic [W-1:0] b, logic c);
    @(posedge clk);
    #2;
    bus.in_valid = v;
    bus.in1      = a;
    bus.in2      = b;
    bus.cin      = c;
  endtask

  // Checks the result captured by the previous step().
  task automatic expect_out(string name, int s, int co, int ov);
    chk({name, "_sum"},   32'(bus.sum),       32'(s));
    chk({name, "_cout"},  32'(bus.cout),      32'(co));
    chk({name, "_valid"}, 32'(bus.out_valid), 32'(ov));
  endtask

  initial begin
    tests        = 0;
    failed       = 0;
    run_cmp      = 1'b0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in1      = '0;
    bus.in2      = '0;
    bus.cin      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    run_cmp = 1'b1;

    step(1, 8'd27, 8'd79, 1'b0);
    step(1, 8'd163, 8'd224, 1'b0);
    expect_out("27p79", 106, 0, 1);
    step(1, 8'd39, 8'd108, 1'b1);
    expect_out("163p224", 131, 1, 1);
    step(1, 8'd204, 8'd192, 1'b1);
    expect_out("39p108c", 148, 0, 1);
    step(1, 8'd255, 8'd0, 1'b1);
    expect_out("204p192c", 141, 1, 1);
    step(1, 8'd255, 8'd255, 1'b1);
    expect_out("ripple", 0, 1, 1);
    step(1, 8'd0, 8'd0, 1'b0);
    expect_out("allones", 255, 1, 1);
    step(1, 8'd200, 8'd100, 1'b0);
    expect_out("zeros", 0, 0, 1);
    step(0, 8'd1, 8'd2, 1'b1);
    expect_out("200p100", 44, 1, 1);
    step(0, 8'd7, 8'd9, 1'b0);
    expect_out("hold", 44, 1, 0);

`ifdef RCA_OVERFLOW_FLAG_EN
    step(1, 8'd127, 8'd1, 1'b0);
    step(1, 8'd163, 8'd224, 1'b0);
    chk("ovf_127p1", 32'(bus.ovf), 32'd1);
    step(1, 8'd27, 8'd79, 1'b0);
    // -93 + -32 = -125 fits in 8 bits signed: carries into and out of the MSB agree.
    chk("ovf_163p224", 32'(bus.ovf), 32'd0);
    step(0, 8'd0, 8'd0, 1'b0);
    chk("ovf_27p79", 32'(bus.ovf), 32'd0);
`endif

    // Asynchronous reset mid-cycle with a nonzero result held.
    step(1, 8'd250, 8'd10, 1'b1);
    step(1, 8'd99, 8'd99, 1'b0);
    expect_out("pre_rst", 5, 1, 1);
    #3;
    rst = 1'b1;
    #1;
    expect_out("async_rst", 0, 0, 0);
    step(1, 8'd50, 8'd60, 1'b0);
    step(1, 8'd11, 8'd22, 1'b0);
    expect_out("rst_hold", 0, 0, 0);
    rst = 1'b0;
    step(0, 8'd0, 8'd0, 1'b0);
    expect_out("post_rst", 33, 0, 1);

    // Randomized traffic with occasional corner operands.
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = W'($urandom);
      case ($urandom_range(0, 7))
        0: a = '1;
        1: b = '1;
        2: begin a = '0; b = '0; end
        default: ;
      endcase
      step(($urandom_range(0, 9) < 7), a, b, 1'($urandom));
    end
    step(0, 0, 0, 0);
    @(negedge clk);
    run_cmp = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_rca_8_bit
`default_nettype wire
